alarm_melody_pwm: RTL and testbench

Audio back-end consuming the alarm-active level produced by the alarm/clock core. While the alarm fires, it steps through an 8-note melody ROM, holding each note for a fixed time followed by a silent gap, and loops until the alarm clears or is silenced. It emits a volume-scaled PWM square wave for the board audio filter and an amplifier enable.

---
 rtl/alarm_melody_pwm.sv | 149 ++++++++++++++
 tb/tb_alarm_melody_pwm.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_melody_pwm.sv
// ---------------------------------------------------------------------------
// alarm_melody_pwm
//
// Audio back-end for the alarm clock. While alarm_i is high it plays an
// 8-note melody from a small ROM, each note sounding for NOTE_CYCLES and
// followed by GAP_CYCLES of silence, looping until the alarm clears or the
// user silences it with off_i. Silencing lasts for the rest of the alarm
// event. The tone square wave is gated by a volume PWM carrier.
//
// Ports:
//   pclk_i      in   clock
//   presetn_i   in   asynchronous active-low reset
//   alarm_i     in   alarm-active level from the alarm core
//   off_i       in   silence request (pulse or level)
//   volume_i    in   PWM duty, 0 = silent
//   aud_pwm_o   out  registered audio PWM output
//   aud_sd_o    out  registered amplifier enable, 1 = on
//   playing_o   out  high while the melody is in a note or gap
//   note_idx_o  out  current melody ROM index
// ---------------------------------------------------------------------------
module alarm_melody_pwm #(
    parameter int NOTE_CYCLES = 5000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int PWM_BITS    = 8,
    parameter int TONE_SHIFT  = 0
) (
    input  logic                pclk_i,
    input  logic                presetn_i,
    input  logic                alarm_i,
    input  logic                off_i,
    input  logic [PWM_BITS-1:0] volume_i,
    output logic                aud_pwm_o,
    output logic                aud_sd_o,
    output logic                playing_o,
    output logic [2:0]          note_idx_o
);

    localparam int CNT_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        GAP   = 2'd2,
        MUTED = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    phase_cnt;   // cycles spent in the current note or gap
    logic [15:0]         tone_cnt;
    logic                tone_phase;
    logic [PWM_BITS-1:0] carrier;
    logic [15:0]         hp;
    logic                pwm_on;

    // Half-period in clock cycles for each melody step; 0 marks a rest.
    function automatic logic [15:0] rom_half_period(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'd47778;  // C5
            3'd1:    return 16'd37921;  // E5
            3'd2:    return 16'd31888;  // G5
            3'd3:    return 16'd23889;  // C6
            3'd4:    return 16'd0;      // rest
            3'd5:    return 16'd31888;
            3'd6:    return 16'd37921;
            default: return 16'd47778;
        endcase
    endfunction

    assign hp        = rom_half_period(note_idx_o) >> TONE_SHIFT;
    assign pwm_on    = (carrier < volume_i);
    assign playing_o = (state == PLAY) || (state == GAP);

    // NOTE: every flop in this block, state and datapath alike, uses non-blocking
    // assignments so all registers update from the same pre-edge values.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            tone_cnt   <= '0;
            tone_phase <= 1'b0;
            carrier    <= '0;
            note_idx_o <= '0;
            aud_pwm_o  <= 1'b0;
            aud_sd_o   <= 1'b0;
        end else begin
            carrier   <= carrier + 1'b1;
            aud_pwm_o <= 1'b0;

            if (state == IDLE) begin
                if (alarm_i && off_i) begin
                    // Alarm and silence arriving together: never make a sound.
                    state <= MUTED;
                end else if (alarm_i) begin
                    state      <= PLAY;
                    aud_sd_o   <= 1'b1;
                    note_idx_o <= '0;
                    phase_cnt  <= '0;
                    tone_cnt   <= '0;
                    tone_phase <= 1'b1;
                end
            end else if (off_i || !alarm_i) begin
                // Silence request wins over alarm clear; both drop everything.
                state      <= off_i ? MUTED : IDLE;
                aud_sd_o   <= 1'b0;
                note_idx_o <= '0;
                phase_cnt  <= '0;
                tone_cnt   <= '0;
                tone_phase <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        aud_pwm_o <= (hp != 16'd0) && tone_phase && pwm_on;
                        if (hp != 16'd0) begin
                            if (tone_cnt == hp - 16'd1) begin
                                tone_cnt   <= '0;
                                tone_phase <= ~tone_phase;
                            end else begin
                                tone_cnt <= tone_cnt + 16'd1;
                            end
                        end
                        if (phase_cnt == CNT_W'(NOTE_CYCLES - 1)) begin
                            state     <= GAP;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (phase_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                            state      <= PLAY;
                            phase_cnt  <= '0;
                            note_idx_o <= note_idx_o + 3'd1;
                            tone_cnt   <= '0;
                            tone_phase <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    default: begin
                        // MUTED with the alarm still high: hold until it clears.
                        state <= MUTED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_melody_pwm.sv
module tb_alarm_melody_pwm;

    localparam int NOTE = 200;
    localparam int GAPC = 20;
    localparam int SH   = 10;
    localparam int PER  = NOTE + GAPC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alarm = 1'b0;
    logic       off = 1'b0;
    logic [7:0] vol = 8'd255;
    logic       aud_pwm, aud_sd, playing;
    logic [2:0] note_idx;

    always #5 clk = ~clk;

    alarm_melody_pwm #(
        .NOTE_CYCLES(NOTE),
        .GAP_CYCLES (GAPC),
        .PWM_BITS   (8),
        .TONE_SHIFT (SH)
    ) dut (
        .pclk_i    (clk),
        .presetn_i (rst_n),
        .alarm_i   (alarm),
        .off_i     (off),
        .volume_i  (vol),
        .aud_pwm_o (aud_pwm),
        .aud_sd_o  (aud_sd),
        .playing_o (playing),
        .note_idx_o(note_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic       pwm;
        logic       sd;
        logic       play;
        logic [2:0] idx;
    } exp_t;

    exp_t sb_q[$];

    typedef enum {M_IDLE, M_RUN, M_MUTED} mmode_t;
    mmode_t     m_mode;
    int         m_s;      // cycles since playback started
    logic [7:0] m_car;
    logic       m_pwm;

    function automatic int hp_of(input int idx);
        int rom [8] = '{47778, 37921, 31888, 23889, 0, 31888, 37921, 47778};
        return rom[idx] >> SH;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_s    = 0;
            m_car  = 8'd0;
            m_pwm  = 1'b0;
            sb_q.delete();
        end else begin
            int   k;
            int   hp;
            exp_t e;
            k     = m_s % PER;
            hp    = hp_of((m_s / PER) % 8);
            m_pwm = (m_mode == M_RUN) && (k < NOTE) && (hp != 0) &&
                    (((k / hp) % 2) == 0) && (m_car < vol);
            if (m_mode == M_IDLE) begin
                if (alarm && off) m_mode = M_MUTED;
                else if (alarm) begin
                    m_mode = M_RUN;
                    m_s    = 0;
                end
            end else if (off) begin
                m_mode = M_MUTED;
                m_pwm  = 1'b0;
            end else if (!alarm) begin
                m_mode = M_IDLE;
                m_pwm  = 1'b0;
            end else if (m_mode == M_RUN) begin
                m_s++;
            end
            m_car = m_car + 8'd1;
            e.pwm  = m_pwm;
            e.sd   = (m_mode == M_RUN);
            e.play = (m_mode == M_RUN);
            e.idx  = (m_mode == M_RUN) ? 3'((m_s / PER) % 8) : 3'd0;
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_pwm",     32'(aud_pwm),  32'(e.pwm));
            check("sb_sd",      32'(aud_sd),   32'(e.sd));
            check("sb_playing", 32'(playing),  32'(e.play));
            check("sb_idx",     32'(note_idx), 32'(e.idx));
        end
    end

    int hi_cnt = 0;
    always @(negedge clk) if (aud_pwm) hi_cnt++;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_pwm"},     32'(aud_pwm),  0);
        check({tag, "_sd"},      32'(aud_sd),   0);
        check({tag, "_playing"}, 32'(playing),  0);
        check({tag, "_idx"},     32'(note_idx), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 check_all_low("reset");
        @(negedge clk) rst_n = 1'b1;
        cycles(5);

        // Basic sequence, rest note and index wrap: nine full notes.
        alarm = 1'b1;
        @(posedge clk);
        #1 check("start_playing", 32'(playing), 1);
        cycles(9 * PER + 20);
        alarm = 1'b0;
        cycles(5);

        // Off pulse in the middle of note 2, then re-arm.
        alarm = 1'b1;
        cycles(2 * PER + 100);
        off = 1'b1;
        cycles(1);
        off = 1'b0;
        check("muted_playing", 32'(playing), 0);
        check("muted_sd",      32'(aud_sd),  0);
        cycles(50);
        alarm = 1'b0;
        cycles(5);
        alarm = 1'b1;
        cycles(300);
        alarm = 1'b0;
        cycles(5);

        // Alarm clears during the gap after note 0.
        alarm = 1'b1;
        cycles(205);
        alarm = 1'b0;
        cycles(1);
        check("clear_idx",     32'(note_idx), 0);
        check("clear_playing", 32'(playing),  0);
        cycles(4);

        // Alarm and off together from IDLE.
        alarm = 1'b1;
        off   = 1'b1;
        cycles(1);
        off = 1'b0;
        check("simul_playing", 32'(playing), 0);
        cycles(30);
        alarm = 1'b0;
        cycles(3);

        // Volume zero: no PWM pulses at all.
        vol = 8'd0;
        #1 hi_cnt = 0;
        alarm = 1'b1;
        cycles(250);
        check("vol0_silent", 32'(hi_cnt), 0);
        alarm = 1'b0;
        cycles(3);

        // Quarter volume.
        vol   = 8'd64;
        alarm = 1'b1;
        cycles(300);

        // Asynchronous reset in the middle of a note.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_low("async_rst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 check("restart_playing", 32'(playing),  1);
        check("restart_idx",        32'(note_idx), 0);
        cycles(100);
        alarm = 1'b0;
        cycles(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
